// File: rtl/prco_regs_pkg.sv
// prco_regs_pkg: shared constants and types for the prco register file.
// Decode and hazard logic use the same default register width and the
// same register-select type, so they are kept here in one place.
//   PRCO_DATA_W : default register width
//   PRCO_ADDR_W : default register-select width
//   PRCO_NREGS  : default register count (2**PRCO_ADDR_W)
//   reg_sel_t   : register-select type at the default width
package prco_regs_pkg;

    localparam int PRCO_DATA_W = 16;
    localparam int PRCO_ADDR_W = 3;
    localparam int PRCO_NREGS  = 2 ** PRCO_ADDR_W;

    typedef logic [PRCO_ADDR_W-1:0] reg_sel_t;

endpackage

// File: rtl/prco_scoreboard.sv
// prco_scoreboard: per-register busy bits for outstanding loads.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_en             : global enable; busy bits hold when 0
//   i_clr, i_clr_sel : clear busy bit (load data written back)
//   i_set, i_set_sel : set busy bit (load issued)
//   i_sela, i_selb   : lookup selects for the two read ports
//   q_busy_vec       : registered busy vector
//   q_busya, q_busyb : busy bit of each lookup select (registered value only)
module prco_scoreboard
    import prco_regs_pkg::*;
#(
    parameter int ADDR_W  = PRCO_ADDR_W,
    parameter int R0_ZERO = 0
)(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [ADDR_W-1:0]     i_clr_sel,
    input  logic                  i_set,
    input  logic [ADDR_W-1:0]     i_set_sel,
    input  logic [ADDR_W-1:0]     i_sela,
    input  logic [ADDR_W-1:0]     i_selb,
    output logic [2**ADDR_W-1:0]  q_busy_vec,
    output logic                  q_busya,
    output logic                  q_busyb
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Set is applied after clear: a lock in the same cycle as the writeback
    // of the previous load to that register means a new load is in flight.
    always_comb begin
        busy_nxt = busy;
        if (i_clr) begin
            busy_nxt[i_clr_sel] = 1'b0;
        end
        if (i_set) begin
            busy_nxt[i_set_sel] = 1'b1;
        end
        if (R0_ZERO != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            busy <= '0;
        end else if (i_en) begin
            busy <= busy_nxt;
        end
    end

    assign q_busy_vec = busy;
    assign q_busya    = busy[i_sela];
    assign q_busyb    = busy[i_selb];

endmodule

// File: rtl/prco_regfile.sv
// prco_regfile: register file for the prco core.
// Two combinational read ports with same-cycle write bypass, two write
// ports (W0 = ALU writeback, W1 = load writeback, W1 wins on collision),
// and a busy-bit scoreboard for outstanding loads.
// Ports:
//   i_clk, i_reset_n         : clock, synchronous active-low reset
//   i_en                     : global enable for all state updates and bypass
//   i_sela/q_data            : read port A select / data
//   i_selb/q_datb            : read port B select / data
//   q_busya, q_busyb         : busy bit of i_sela / i_selb
//   i_we0, i_seld0, i_datd0  : write port W0
//   i_we1, i_seld1, i_datd1  : write port W1 (also clears busy of target)
//   i_lock, i_lock_sel       : mark a register busy (load issued)
//   q_busy_vec               : registered busy bits
//   q_wr_conflict            : previous enabled cycle had W0/W1 to same register
module prco_regfile
    import prco_regs_pkg::*;
#(
    parameter int                DATA_W    = PRCO_DATA_W,
    parameter int                ADDR_W    = PRCO_ADDR_W,
    parameter int                R0_ZERO   = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
)(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic [ADDR_W-1:0]     i_sela,
    output logic [DATA_W-1:0]     q_data,
    input  logic [ADDR_W-1:0]     i_selb,
    output logic [DATA_W-1:0]     q_datb,
    output logic                  q_busya,
    output logic                  q_busyb,
    input  logic                  i_we0,
    input  logic [ADDR_W-1:0]     i_seld0,
    input  logic [DATA_W-1:0]     i_datd0,
    input  logic                  i_we1,
    input  logic [ADDR_W-1:0]     i_seld1,
    input  logic [DATA_W-1:0]     i_datd1,
    input  logic                  i_lock,
    input  logic [ADDR_W-1:0]     i_lock_sel,
    output logic [2**ADDR_W-1:0]  q_busy_vec,
    output logic                  q_wr_conflict
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_conflict;
    logic              bypass_ok;
    logic              w0_ok;
    logic              w1_ok;

    // Bypass only reflects writes that will actually commit this edge.
    assign bypass_ok = i_en && i_reset_n;
    assign w0_ok     = i_we0 && !((R0_ZERO != 0) && (i_seld0 == '0));
    assign w1_ok     = i_we1 && !((R0_ZERO != 0) && (i_seld1 == '0));

    // W1 is assigned last so it overrides W0 on a same-register collision.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_conflict <= 1'b0;
        end else if (i_en) begin
            wr_conflict <= i_we0 && i_we1 && (i_seld0 == i_seld1);
            if (w0_ok) begin
                regs[i_seld0] <= i_datd0;
            end
            if (w1_ok) begin
                regs[i_seld1] <= i_datd1;
            end
        end
    end

    assign q_wr_conflict = wr_conflict;

    // Read muxes: later assignments have higher priority
    // (stored < W0 bypass < W1 bypass < hard zero).
    always_comb begin
        q_data = regs[i_sela];
        if (bypass_ok && i_we0 && (i_seld0 == i_sela)) begin
            q_data = i_datd0;
        end
        if (bypass_ok && i_we1 && (i_seld1 == i_sela)) begin
            q_data = i_datd1;
        end
        if ((R0_ZERO != 0) && (i_sela == '0)) begin
            q_data = '0;
        end
    end

    always_comb begin
        q_datb = regs[i_selb];
        if (bypass_ok && i_we0 && (i_seld0 == i_selb)) begin
            q_datb = i_datd0;
        end
        if (bypass_ok && i_we1 && (i_seld1 == i_selb)) begin
            q_datb = i_datd1;
        end
        if ((R0_ZERO != 0) && (i_selb == '0)) begin
            q_datb = '0;
        end
    end

    prco_scoreboard #(
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_clr      (i_we1),
        .i_clr_sel  (i_seld1),
        .i_set      (i_lock),
        .i_set_sel  (i_lock_sel),
        .i_sela     (i_sela),
        .i_selb     (i_selb),
        .q_busy_vec (q_busy_vec),
        .q_busya    (q_busya),
        .q_busyb    (q_busyb)
    );

endmodule

// File: tb/tb_prco_regfile.sv
// Bench for prco_regfile: two instances share all inputs, one with
// R0_ZERO=0 and one with R0_ZERO=1. A behavioural model of both is
// compared against every output on each falling edge; directed steps
// add literal expectations before a randomized phase.
module tb_prco_regfile;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  sela, selb;
    logic        we0, we1, lock;
    logic [2:0]  seld0, seld1, lock_sel;
    logic [15:0] datd0, datd1;

    logic [15:0] d0_data, d0_datb, d1_data, d1_datb;
    logic        d0_busya, d0_busyb, d1_busya, d1_busyb;
    logic [7:0]  d0_bvec, d1_bvec;
    logic        d0_conf, d1_conf;

    int checks = 0;
    int errors = 0;

    // model state, index 0: R0_ZERO=0, index 1: R0_ZERO=1
    logic [15:0] mregs [2][8];
    logic [7:0]  mbusy [2];
    logic        mconf [2];
    bit          model_valid = 0;

    prco_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(0), .RESET_VAL(16'h0000)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
        .i_sela(sela), .q_data(d0_data), .i_selb(selb), .q_datb(d0_datb),
        .q_busya(d0_busya), .q_busyb(d0_busyb),
        .i_we0(we0), .i_seld0(seld0), .i_datd0(datd0),
        .i_we1(we1), .i_seld1(seld1), .i_datd1(datd1),
        .i_lock(lock), .i_lock_sel(lock_sel),
        .q_busy_vec(d0_bvec), .q_wr_conflict(d0_conf)
    );

    prco_regfile #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1), .RESET_VAL(16'h0000)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en),
        .i_sela(sela), .q_data(d1_data), .i_selb(selb), .q_datb(d1_datb),
        .q_busya(d1_busya), .q_busyb(d1_busyb),
        .i_we0(we0), .i_seld0(seld0), .i_datd0(datd0),
        .i_we1(we1), .i_seld1(seld1), .i_datd1(datd1),
        .i_lock(lock), .i_lock_sel(lock_sel),
        .q_busy_vec(d1_bvec), .q_wr_conflict(d1_conf)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected combinational read from the model
    function automatic logic [15:0] exp_read(input int d, input logic [2:0] sel);
        if (d == 1 && sel == 3'd0) return 16'h0000;
        if (rst_n && en && we1 && seld1 == sel) return datd1;
        if (rst_n && en && we0 && seld0 == sel) return datd0;
        return mregs[d][sel];
    endfunction

    // next-state of the model from the current inputs
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int r = 0; r < 8; r++) mregs[d][r] = 16'h0000;
                mbusy[d] = 8'h00;
                mconf[d] = 1'b0;
            end else if (en) begin
                mconf[d] = we0 && we1 && (seld0 == seld1);
                if (we0 && !(d == 1 && seld0 == 3'd0)) mregs[d][seld0] = datd0;
                if (we1 && !(d == 1 && seld1 == 3'd0)) mregs[d][seld1] = datd1;
                if (we1) mbusy[d][seld1] = 1'b0;
                if (lock) mbusy[d][lock_sel] = 1'b1;
                if (d == 1) mbusy[d][0] = 1'b0;
            end
        end
    endtask

    // compare process: inputs change just after posedge, so negedge sees
    // stable inputs and settled outputs; the model then advances to the
    // state the coming posedge commits.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("d0_data",  32'(d0_data),  32'(exp_read(0, sela)));
                chk("d0_datb",  32'(d0_datb),  32'(exp_read(0, selb)));
                chk("d0_busya", 32'(d0_busya), 32'(mbusy[0][sela]));
                chk("d0_busyb", 32'(d0_busyb), 32'(mbusy[0][selb]));
                chk("d0_bvec",  32'(d0_bvec),  32'(mbusy[0]));
                chk("d0_conf",  32'(d0_conf),  32'(mconf[0]));
                chk("d1_data",  32'(d1_data),  32'(exp_read(1, sela)));
                chk("d1_datb",  32'(d1_datb),  32'(exp_read(1, selb)));
                chk("d1_busya", 32'(d1_busya), 32'(mbusy[1][sela]));
                chk("d1_busyb", 32'(d1_busyb), 32'(mbusy[1][selb]));
                chk("d1_bvec",  32'(d1_bvec),  32'(mbusy[1]));
                chk("d1_conf",  32'(d1_conf),  32'(mconf[1]));
            end
            model_step();
            if (!rst_n) model_valid = 1;
        end
    end

    // driver tasks
    task automatic idle();
        rst_n = 1'b1; en = 1'b1;
        we0 = 1'b0; we1 = 1'b0; lock = 1'b0;
        seld0 = 3'd0; seld1 = 3'd0; lock_sel = 3'd0;
        datd0 = 16'h0000; datd1 = 16'h0000;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    // wait for combinational settle before literal checks
    task automatic settle();
        #2;
    endtask

    task automatic drive_random();
        rst_n    = ($urandom_range(0, 49) != 0);
        en       = ($urandom_range(0, 9) != 0);
        we0      = 1'($urandom_range(0, 1));
        we1      = 1'($urandom_range(0, 1));
        lock     = ($urandom_range(0, 3) == 0);
        seld0    = 3'($urandom_range(0, 7));
        seld1    = 3'($urandom_range(0, 7));
        lock_sel = 3'($urandom_range(0, 7));
        datd0    = 16'($urandom);
        datd1    = 16'($urandom);
        sela     = 3'($urandom_range(0, 7));
        selb     = 3'($urandom_range(0, 7));
    endtask

    initial begin
        idle();
        sela = 3'd0; selb = 3'd0;
        #1;

        // 1. reset with a write pending: write must be discarded
        rst_n = 1'b0; we0 = 1'b1; seld0 = 3'd3; datd0 = 16'h1234;
        next_cycle();
        sela = 3'd3; selb = 3'd1;
        settle();
        chk("rst_reg3", 32'(d0_data), 32'h0000);
        chk("rst_bvec", 32'(d0_bvec), 32'h00);
        chk("rst_conf", 32'(d0_conf), 32'h0);

        // 2. W0 bypass then stored read
        next_cycle();
        we0 = 1'b1; seld0 = 3'd1; datd0 = 16'hf0f0; sela = 3'd1;
        settle();
        chk("byp_w0", 32'(d0_data), 32'hf0f0);
        next_cycle();
        sela = 3'd1;
        settle();
        chk("stored_w0", 32'(d0_data), 32'hf0f0);

        // 3. collision: W1 wins, conflict flag for one cycle
        next_cycle();
        we0 = 1'b1; seld0 = 3'd2; datd0 = 16'h1111;
        we1 = 1'b1; seld1 = 3'd2; datd1 = 16'h2222; sela = 3'd2;
        settle();
        chk("coll_byp", 32'(d0_data), 32'h2222);
        chk("coll_conf_pre", 32'(d0_conf), 32'h0);
        next_cycle();
        sela = 3'd2;
        settle();
        chk("coll_stored", 32'(d0_data), 32'h2222);
        chk("coll_conf", 32'(d0_conf), 32'h1);
        next_cycle();
        settle();
        chk("coll_conf_clr", 32'(d0_conf), 32'h0);

        // 4. scoreboard lock / clear / lock-wins
        next_cycle();
        lock = 1'b1; lock_sel = 3'd5; sela = 3'd5;
        settle();
        chk("lock_same_cyc", 32'(d0_busya), 32'h0);
        next_cycle();
        sela = 3'd5; we1 = 1'b1; seld1 = 3'd5; datd1 = 16'hbeef;
        settle();
        chk("lock_busya", 32'(d0_busya), 32'h1);
        chk("lock_bvec5", 32'(d0_bvec[5]), 32'h1);
        chk("w1_byp", 32'(d0_data), 32'hbeef);
        next_cycle();
        sela = 3'd5;
        settle();
        chk("w1_clear", 32'(d0_busya), 32'h0);
        next_cycle();
        sela = 3'd5; lock = 1'b1; lock_sel = 3'd5;
        we1 = 1'b1; seld1 = 3'd5; datd1 = 16'hbeef;
        next_cycle();
        sela = 3'd5;
        settle();
        chk("lock_wins", 32'(d0_busya), 32'h1);
        chk("lock_wins_dat", 32'(d0_data), 32'hbeef);

        // 5. enable gating
        next_cycle();
        en = 1'b0; we0 = 1'b1; seld0 = 3'd4; datd0 = 16'haaaa;
        lock = 1'b1; lock_sel = 3'd4; sela = 3'd4;
        settle();
        chk("en0_nobyp", 32'(d0_data), 32'h0000);
        next_cycle();
        sela = 3'd4;
        settle();
        chk("en0_reg4", 32'(d0_data), 32'h0000);
        chk("en0_busy4", 32'(d0_bvec[4]), 32'h0);

        // 6. R0_ZERO instance: writes/locks to reg 0 ignored; reset clears busy
        next_cycle();
        we0 = 1'b1; seld0 = 3'd0; datd0 = 16'hffff;
        lock = 1'b1; lock_sel = 3'd0; sela = 3'd0;
        settle();
        chk("r0z_byp", 32'(d1_data), 32'h0000);
        chk("r0n_byp", 32'(d0_data), 32'hffff);
        next_cycle();
        sela = 3'd0; lock = 1'b1; lock_sel = 3'd6;
        settle();
        chk("r0z_busy0", 32'(d1_bvec[0]), 32'h0);
        chk("r0n_busy0", 32'(d0_bvec[0]), 32'h1);
        chk("r0z_data0", 32'(d1_data), 32'h0000);
        next_cycle();
        settle();
        chk("busy6_set", 32'(d1_bvec[6]), 32'h1);
        rst_n = 1'b0; lock = 1'b1; lock_sel = 3'd6;
        next_cycle();
        settle();
        chk("rst_busy_d1", 32'(d1_bvec), 32'h00);
        chk("rst_busy_d0", 32'(d0_bvec), 32'h00);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            drive_random();
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prco_regfile.md
Name: prco_regfile

Overview:
- Parametrised next-generation register file for the prco core.
- Provides two combinational read ports and two write ports: port W0 for ALU writeback, port W1 for memory/load writeback.
- Same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits) so decode can stall on registers with an outstanding load.
- Sits between decode (read/lock), execute (W0) and the memory stage (W1).

Parameters:
- DATA_W, 16, width of each register.
- ADDR_W, 3, register select width; depth NREGS = 2**ADDR_W.
- R0_ZERO, 0, when 1, register 0 reads as zero, ignores writes and is never busy.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- i_clk  in  1  single clock; all state updates on posedge.
- i_reset_n  in  1  synchronous reset, active-low.
- i_en  in  1  global enable; when 0, no register, busy-bit or conflict-flag update occurs.
- i_sela  in  ADDR_W  read port A select.
- q_data  out  DATA_W  read port A data.
- i_selb  in  ADDR_W  read port B select.
- q_datb  out  DATA_W  read port B data.
- q_busya  out  1  busy bit of i_sela.
- q_busyb  out  1  busy bit of i_selb.
- i_we0  in  1  write enable, port W0.
- i_seld0  in  ADDR_W  write select, port W0.
- i_datd0  in  DATA_W  write data, port W0.
- i_we1  in  1  write enable, port W1; also clears the busy bit of the target.
- i_seld1  in  ADDR_W  write select, port W1.
- i_datd1  in  DATA_W  write data, port W1.
- i_lock  in  1  set busy bit of i_lock_sel (load issued).
- i_lock_sel  in  ADDR_W  register to mark busy.
- q_busy_vec  out  NREGS  all busy bits, registered.
- q_wr_conflict  out  1  registered flag: the previous enabled cycle had W0 and W1 to the same register.

Behaviour:
- Reset: when i_reset_n=0 at posedge, all registers <= RESET_VAL, all busy bits <= 0, q_wr_conflict <= 0. Reset overrides i_en and all writes/locks that cycle.
- Write: on posedge with i_en=1, the selected register takes the write data, visible to plain reads the following cycle. W0 and W1 to different registers both commit.
- Write collision: W0 and W1 to the same register in the same cycle → W1 data commits; q_wr_conflict <= 1 for one cycle, otherwise 0.
- Read: combinational, zero latency. Priority per port:
  1. R0_ZERO and sel==0 → 0.
  2. Otherwise, sel matches an active i_we1 target → i_datd1.
  3. Otherwise, sel matches an active i_we0 target → i_datd0.
  4. Otherwise, stored value.
- Bypass is qualified by i_en and i_reset_n=1; no bypass during reset or when i_en=0.
- Scoreboard: on posedge with i_en=1, i_we1 clears busy[i_seld1]; i_lock sets busy[i_lock_sel]. When both hit the same register, lock wins (busy stays 1; a new load was issued). W0 writes never touch busy bits.
- q_busya/q_busyb: combinational lookup of q_busy_vec; no bypass of same-cycle lock/clear.
- R0_ZERO=1: writes and locks to register 0 are ignored; busy[0] is always 0.
- i_en=0: all state holds; reads still return stored values without bypass.

Decomposition:
- Shared package prco_regs_pkg holds the default DATA_W and ADDR_W constants and the reg-select typedef, shared with decode/hazard logic.
- One natural sub-module: prco_scoreboard (busy-bit vector with set/clear priority, q_busy_vec, per-port lookup).
- The storage array and bypass muxes stay in the top module.

Test Plan:
1. Reset: i_reset_n=0 for one cycle with i_we0=1, sel 3, data 16'h1234 → all registers read 0, q_busy_vec=0; reg 3 remains 0.
2. Write/read/bypass: W0 sel 1 data 16'hf0f0 with i_sela=1 in the same cycle → q_data=16'hf0f0 combinationally. Next cycle with i_we0=0 → still 16'hf0f0.
3. Collision: W0 sel 2 data 16'h1111 and W1 sel 2 data 16'h2222 → same-cycle read of 2 shows 16'h2222; q_wr_conflict=1 for exactly one cycle; stored value 16'h2222.
4. Scoreboard: lock sel 5 → q_busy_vec[5]=1, q_busya=1 with i_sela=5. W1 sel 5 data 16'hbeef → busy clears next cycle. Lock sel 5 and W1 sel 5 in the same cycle → busy stays 1, data 16'hbeef written.
5. Enable gating: i_en=0 with W0 sel 4 data 16'haaaa and lock sel 4 → reg 4 unchanged, busy[4]=0, no bypass.
6. R0_ZERO=1 build: W0 sel 0 data 16'hffff and lock sel 0 → q_data (sel 0)=0, busy[0]=0; reset mid-lock on reg 6 clears busy[6].
